// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit register-write frames {R/W, addr[6:0], data[7:0]}, MSB first.
// Define SPI_CONTROLLER_READBACK_EN to capture CIPO into rsp_data on read frames.
module spi_controller #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  input  logic       CIPO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic [7:0] H_LOAD = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] G_LOAD = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [14:0] shift_q, shift_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;
  logic        cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  assign req_ready = (state_q == ST_IDLE);
  assign nCS       = ncs_q;
  assign SCLK      = sclk_q;
  assign COPI      = copi_q;
  assign done      = done_q;

`ifdef SPI_CONTROLLER_READBACK_EN
  logic       cipo_meta_q, cipo_sync_q;
  logic       rd_q, rd_d;
  logic [7:0] rx_q, rx_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  logic unused_cipo;

  assign unused_cipo = CIPO;
  assign rsp_valid   = 1'b0;
  assign rsp_data    = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
`ifdef SPI_CONTROLLER_READBACK_EN
    rd_d        = rd_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`endif
    if (!cnt_zero) cnt_d = cnt_q - 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          shift_d = {req_addr, req_data};
          copi_d  = req_write;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          cnt_d   = H_LOAD;
          state_d = ST_SETUP;
`ifdef SPI_CONTROLLER_READBACK_EN
          rd_d = ~req_write;
          rx_d = '0;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          sclk_d  = 1'b1;
          cnt_d   = H_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
          cnt_d = H_LOAD;
          if (sclk_q) begin
            sclk_d = 1'b0;
`ifdef SPI_CONTROLLER_READBACK_EN
            if (rd_q && bit_q[3]) rx_d = {rx_q[6:0], cipo_sync_q};
`endif
            // The low half after bit 15 is the HOLD phase; COPI keeps the last bit.
            if (bit_q == 4'd15) begin
              state_d = ST_HOLD;
            end else begin
              copi_d  = shift_q[14];
              shift_d = {shift_q[13:0], 1'b0};
              bit_d   = bit_q + 4'd1;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = G_LOAD;
          state_d = ST_GAP;
`ifdef SPI_CONTROLLER_READBACK_EN
          rsp_valid_d = rd_q;
          if (rd_q) rsp_data_d = rx_q;
`endif
        end
      end
      ST_GAP: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_meta_q <= 1'b0;
      cipo_sync_q <= 1'b0;
      rd_q        <= 1'b0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      cipo_meta_q <= CIPO;
      cipo_sync_q <= cipo_meta_q;
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a line monitor rebuilds frames and a peripheral
// model drives CIPO; expected frames and timing come from the frame layout and edge formulas.
module tb_spi_controller;
  localparam int H = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       CIPO = 1'b0;
  logic       req_ready, done, nCS, SCLK, COPI, rsp_valid;
  logic [7:0] rsp_data;

  int errors = 0;
  int checks = 0;

  spi_controller #(.HALF_PERIOD(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .done(done), .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Monitor state, sampled on the falling clock edge
  int          cyc = 0;
  logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_ready = 1'b0;
  int          cur_n = 0, cur_fall = 0, cur_bad = 0, n_fall = 0;
  int          last_chg = 0, last_rise = -1000, stab_err = 0;
  logic [15:0] cur_w = '0;
  logic [15:0] fr_word[$];
  int          fr_n[$], fr_fall[$], fr_rise[$], fr_bad[$];
  int          done_cnt = 0, done_t = 0, rsp_cnt = 0, rsp_t = 0, ready_t = 0;
  logic [7:0]  rsp_last = '0;
  logic [7:0]  cipo_byte = '0;

  always @(negedge clk) begin
    cyc++;
    if (p_ncs && !nCS) begin
      cur_n = 0; cur_w = '0; cur_fall = cyc; cur_bad = 0; n_fall = 0;
      last_chg = cyc; last_rise = -1000;
    end
    if (!nCS) begin
      if (!p_sclk && SCLK) begin
        if (cyc != cur_fall + H + 2 * H * cur_n) cur_bad++;
        if (cyc - last_chg < H) stab_err++;
        cur_w = {cur_w[14:0], COPI};
        cur_n++;
        last_rise = cyc;
      end
      if (!p_ncs && COPI !== p_copi) begin
        if (cyc - last_rise < H) stab_err++;
        last_chg = cyc;
      end
      if (p_sclk && !SCLK) begin
        n_fall++;
        if (n_fall >= 8 && n_fall <= 15) CIPO = cipo_byte[3'(15 - n_fall)];
      end
    end
    if (!p_ncs && nCS) begin
      fr_word.push_back(cur_w); fr_n.push_back(cur_n); fr_fall.push_back(cur_fall);
      fr_rise.push_back(cyc); fr_bad.push_back(cur_bad);
      CIPO = 1'b0;
    end
    if (done) begin done_cnt++; done_t = cyc; end
    if (rsp_valid) begin rsp_cnt++; rsp_t = cyc; rsp_last = rsp_data; end
    if (req_ready && !p_ready) ready_t = cyc;
    p_ncs = nCS; p_sclk = SCLK; p_copi = COPI; p_ready = req_ready;
  end

  function automatic logic [15:0] exp_word(input int w, input int a, input int d);
    return 16'(w * 32768 + a * 256 + d);
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready) begin acc = cyc; break; end
      step();
    end
    checks++;
    if (acc < 0) begin errors++; $display("FAIL accept_timeout: ready never seen, required 1"); end
  endtask

  task automatic wait_frames(input int n);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (fr_word.size() >= n) break;
      step();
    end
    checks++;
    if (fr_word.size() < n) begin
      errors++; $display("FAIL frame_timeout: frames=%0d required %0d", fr_word.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks += 4;
    if (nCS !== 1'b1) begin errors++; $display("FAIL rst_ncs: got %b required 1", nCS); end
    if (SCLK !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b required 0", SCLK); end
    if (COPI !== 1'b0) begin errors++; $display("FAIL rst_copi: got %b required 0", COPI); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    rst_n = 1'b1;
    step();
    checks += 3;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h required 00", rsp_data); end
  endtask

  task automatic test_write();
    int acc, n0, d0;
    n0 = fr_word.size(); d0 = done_cnt;
    issue(1'b1, 7'h02, 8'hA5, acc);
    step(); req_valid = 1'b0;
    wait_frames(n0 + 1);
    repeat (G + 3) step();
    if (fr_word.size() > n0) begin
      checks += 8;
      if (fr_word[n0] !== 16'h82A5) begin errors++; $display("FAIL wr_frame: got %h required 82a5", fr_word[n0]); end
      if (fr_n[n0] != 16) begin errors++; $display("FAIL wr_edges: got %0d required 16", fr_n[n0]); end
      if (fr_fall[n0] != acc + 1) begin errors++; $display("FAIL wr_ncs_fall: got %0d required %0d", fr_fall[n0], acc + 1); end
      if (fr_rise[n0] - fr_fall[n0] != 33 * H) begin
        errors++; $display("FAIL wr_ncs_low: got %0d required %0d", fr_rise[n0] - fr_fall[n0], 33 * H);
      end
      if (fr_bad[n0] != 0) begin errors++; $display("FAIL wr_edge_times: bad=%0d required 0", fr_bad[n0]); end
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_count: got %0d required 1", done_cnt - d0); end
      if (done_t != fr_rise[n0]) begin errors++; $display("FAIL wr_done_time: got %0d required %0d", done_t, fr_rise[n0]); end
      if (ready_t != fr_rise[n0] + G) begin
        errors++; $display("FAIL wr_ready_time: got %0d required %0d", ready_t, fr_rise[n0] + G);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, n0;
    n0 = fr_word.size();
    issue(1'b1, 7'h00, 8'hFF, acc1);
    step();
    req_addr = 7'h04; req_data = 8'h80;
    issue(1'b1, 7'h04, 8'h80, acc2);
    step(); req_valid = 1'b0;
    wait_frames(n0 + 2);
    if (fr_word.size() > n0 + 1) begin
      checks += 4;
      if (fr_word[n0] !== 16'h80FF) begin errors++; $display("FAIL b2b_frame1: got %h required 80ff", fr_word[n0]); end
      if (fr_word[n0 + 1] !== 16'h8480) begin errors++; $display("FAIL b2b_frame2: got %h required 8480", fr_word[n0 + 1]); end
      if (fr_fall[n0 + 1] - fr_rise[n0] != G + 1) begin
        errors++; $display("FAIL b2b_gap: got %0d required %0d", fr_fall[n0 + 1] - fr_rise[n0], G + 1);
      end
      if (fr_n[n0 + 1] != 16) begin errors++; $display("FAIL b2b_edges: got %0d required 16", fr_n[n0 + 1]); end
    end
  endtask

  task automatic test_ignore_busy();
    int acc, n0, d0, i;
    n0 = fr_word.size(); d0 = done_cnt;
    issue(1'b1, 7'h10, 8'h33, acc);
    step(); req_valid = 1'b0;
    for (i = 0; i < 500 && cur_n < 3; i++) step();
    req_write = 1'b1; req_addr = 7'h10; req_data = 8'h11; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    wait_frames(n0 + 1);
    repeat (40 * H) step();
    checks += 3;
    if (fr_word.size() != n0 + 1) begin errors++; $display("FAIL busy_frames: got %0d required %0d", fr_word.size(), n0 + 1); end
    else if (fr_word[n0] !== 16'h9033) begin errors++; $display("FAIL busy_frame: got %h required 9033", fr_word[n0]); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    int acc, n0, d0, i;
    n0 = fr_word.size(); d0 = done_cnt;
    issue(1'b1, 7'h07, 8'h66, acc);
    step(); req_valid = 1'b0;
    for (i = 0; i < 500 && cur_n < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (nCS !== 1'b1) begin errors++; $display("FAIL midrst_ncs: got %b required 1", nCS); end
    if (SCLK !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b required 0", SCLK); end
    if (COPI !== 1'b0) begin errors++; $display("FAIL midrst_copi: got %b required 0", COPI); end
    step(); step();
    rst_n = 1'b1;
    step();
    checks += 2;
    if (fr_word.size() != n0 + 1 || fr_n[fr_n.size() - 1] >= 16) begin
      errors++; $display("FAIL midrst_partial: frames=%0d required %0d with under 16 edges", fr_word.size(), n0 + 1);
    end
    if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d required %0d", done_cnt, d0); end
    issue(1'b1, 7'h03, 8'h5A, acc);
    step(); req_valid = 1'b0;
    wait_frames(n0 + 2);
    if (fr_word.size() > n0 + 1) begin
      checks += 2;
      if (fr_word[n0 + 1] !== 16'h835A) begin errors++; $display("FAIL midrst_after: got %h required 835a", fr_word[n0 + 1]); end
      if (fr_n[n0 + 1] != 16) begin errors++; $display("FAIL midrst_after_edges: got %0d required 16", fr_n[n0 + 1]); end
    end
  endtask

  task automatic test_readback();
    int acc, n0, r0;
    logic [7:0] d;
    n0 = fr_word.size(); r0 = rsp_cnt;
`ifdef SPI_CONTROLLER_READBACK_EN
    cipo_byte = 8'h3C; d = 8'h00;
    issue(1'b0, 7'h04, d, acc);
    step(); req_valid = 1'b0;
    wait_frames(n0 + 1);
    repeat (3) step();
    checks += 4;
    if (fr_word.size() > n0 && fr_word[n0] !== 16'h0400) begin errors++; $display("FAIL rb_frame: got %h required 0400", fr_word[n0]); end
    if (rsp_cnt - r0 != 1) begin errors++; $display("FAIL rb_valid_count: got %0d required 1", rsp_cnt - r0); end
    if (rsp_last !== 8'h3C) begin errors++; $display("FAIL rb_data: got %h required 3c", rsp_last); end
    if (rsp_t != done_t) begin errors++; $display("FAIL rb_valid_time: got %0d required %0d", rsp_t, done_t); end
`else
    cipo_byte = 8'hC3; d = 8'($urandom);
    issue(1'b0, 7'h01, d, acc);
    step(); req_valid = 1'b0;
    wait_frames(n0 + 1);
    repeat (3) step();
    checks += 3;
    if (fr_word.size() > n0 && fr_word[n0] !== exp_word(0, 1, int'(d))) begin
      errors++; $display("FAIL nrb_frame: got %h required %h", fr_word[n0], exp_word(0, 1, int'(d)));
    end
    if (rsp_cnt != 0) begin errors++; $display("FAIL nrb_valid: got %0d required 0", rsp_cnt); end
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL nrb_data: got %h required 00", rsp_data); end
`endif
  endtask

  task automatic test_random();
    int acc, n0, d0, r0, w, a, d;
    for (int k = 0; k < 8; k++) begin
      w = int'($urandom_range(0, 1)); a = int'($urandom_range(0, 127)); d = int'($urandom_range(0, 255));
      cipo_byte = 8'($urandom);
      n0 = fr_word.size(); d0 = done_cnt; r0 = rsp_cnt;
      issue(w[0], 7'(a), 8'(d), acc);
      step(); req_valid = 1'b0;
      wait_frames(n0 + 1);
      repeat (3) step();
      if (fr_word.size() > n0) begin
        checks += 4;
        if (fr_word[n0] !== exp_word(w, a, d)) begin
          errors++; $display("FAIL rnd_frame[%0d]: got %h required %h", k, fr_word[n0], exp_word(w, a, d));
        end
        if (fr_bad[n0] != 0 || fr_n[n0] != 16) begin
          errors++; $display("FAIL rnd_edges[%0d]: bad=%0d n=%0d required 0 and 16", k, fr_bad[n0], fr_n[n0]);
        end
        if (fr_rise[n0] - fr_fall[n0] != 33 * H) begin
          errors++; $display("FAIL rnd_ncs_low[%0d]: got %0d required %0d", k, fr_rise[n0] - fr_fall[n0], 33 * H);
        end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd_done[%0d]: got %0d required 1", k, done_cnt - d0); end
      end
`ifdef SPI_CONTROLLER_READBACK_EN
      checks++;
      if (rsp_cnt - r0 != (w == 0 ? 1 : 0)) begin
        errors++; $display("FAIL rnd_rsp_count[%0d]: got %0d required %0d", k, rsp_cnt - r0, (w == 0 ? 1 : 0));
      end
      if (w == 0) begin
        checks++;
        if (rsp_last !== cipo_byte) begin errors++; $display("FAIL rnd_rsp_data[%0d]: got %h required %h", k, rsp_last, cipo_byte); end
      end
`else
      checks++;
      if (rsp_cnt != r0) begin errors++; $display("FAIL rnd_rsp_count[%0d]: got %0d required %0d", k, rsp_cnt, r0); end
`endif
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL copi_stability: violations=%0d required 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_readback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
